// File: rtl/gen_sync_filter.sv
// Multi-channel input conditioner: per-channel flop synchroniser followed by a glitch filter with edge pulses.
// Latency: din stable before edge E1 shows on dout at edge E(DP+FILT); rise/fall/any_edge land with dout.
// No backpressure: free-running every cycle; en=0 freezes filter counters and dout and silences the edge outputs.
module gen_sync_filter #(
    parameter int               NCH     = 4,
    parameter int               DP      = 2,
    parameter int               FILT    = 4,
    parameter logic [NCH-1:0]   RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NCH-1:0]  din,
    output logic [NCH-1:0]  dout,
    output logic [NCH-1:0]  rise,
    output logic [NCH-1:0]  fall,
    output logic            any_edge
);

    localparam int              CW       = (FILT < 1) ? 1 : $clog2(FILT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILT - 1);

    generate
        if (NCH < 1 || DP < 2 || FILT < 1) begin : g_bad_params
            $error("gen_sync_filter: illegal parameters (need NCH>=1, DP>=2, FILT>=1)");
        end
    endgenerate

    logic [NCH-1:0] sync_q [DP];
    logic [NCH-1:0] s;

    // The synchroniser keeps shifting while the filter is disabled so en=1 resumes on fresh samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DP; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < DP; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[DP-1];

    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] dout_d;
    logic [NCH-1:0] rise_d;
    logic [NCH-1:0] fall_d;

    // Any sample agreeing with dout restarts the count, so only an unbroken run of FILT differing samples is accepted.
    always_comb begin
        dout_d = dout;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (en) begin
                if (s[i] == dout[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]  = '0;
                    dout_d[i] = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            dout     <= RST_VAL;
            rise     <= '0;
            fall     <= '0;
            any_edge <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dout     <= dout_d;
            rise     <= rise_d;
            fall     <= fall_d;
            any_edge <= |(rise_d | fall_d);
        end
    end

endmodule

// File: tb/tb_gen_sync_filter.sv
// Directed bench: default-parameter instance driven from a vector table plus multi-cycle corner sequences,
// and a DP=3 / FILT=1 / non-zero reset-level instance for short latency and reset value.
module tb_gen_sync_filter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en;
    logic [3:0] din, dout, rise, fall;
    logic       any_edge;

    logic       rst2, en2;
    logic [3:0] din2, dout2, rise2, fall2;
    logic       any_edge2;

    gen_sync_filter #(.NCH(4), .DP(2), .FILT(4), .RST_VAL(4'b0000)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .any_edge (any_edge)
    );

    gen_sync_filter #(.NCH(4), .DP(3), .FILT(1), .RST_VAL(4'b0101)) u_dut2 (
        .clk      (clk),
        .rst      (rst2),
        .en       (en2),
        .din      (din2),
        .dout     (dout2),
        .rise     (rise2),
        .fall     (fall2),
        .any_edge (any_edge2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] din;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic e, input logic [3:0] d,
                                input logic [3:0] o, input logic [3:0] ri, input logic [3:0] fa);
        vec_t v;
        v.rst  = r;
        v.en   = e;
        v.din  = d;
        v.dout = o;
        v.rise = ri;
        v.fall = fa;
        v.any  = |(ri | fa);
        vq.push_back(v);
    endfunction

    // din switches to new_v before the first edge; dout follows on the 6th edge, then one quiet cycle.
    function automatic void add_change(input logic [3:0] old_v, input logic [3:0] new_v);
        for (int k = 1; k <= 7; k++) begin
            add(1'b0, 1'b1, new_v, (k >= 6) ? new_v : old_v,
                (k == 6) ? (new_v & ~old_v) : 4'b0000,
                (k == 6) ? (old_v & ~new_v) : 4'b0000);
        end
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        din  = 4'b0000;
        rst2 = 1'b1;
        en2  = 1'b1;
        din2 = 4'b0101;

        for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 2; k++) add(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_change(4'b0000, 4'b0001);
        add_change(4'b0001, 4'b0000);
        add_change(4'b0000, 4'b1111);
        add_change(4'b1111, 4'b0000);
        add_change(4'b0000, 4'b1010);
        add_change(4'b1010, 4'b0101);
        add_change(4'b0101, 4'b0000);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            en  = vq[i].en;
            din = vq[i].din;
            step();
            check($sformatf("vec%0d dout", i), dout, vq[i].dout);
            check($sformatf("vec%0d rise", i), rise, vq[i].rise);
            check($sformatf("vec%0d fall", i), fall, vq[i].fall);
            check($sformatf("vec%0d any_edge", i), {3'b000, any_edge}, {3'b000, vq[i].any});
        end

        check("dut2 reset dout", dout2, 4'b0101);
        check("dut2 reset edges", rise2 | fall2 | {3'b000, any_edge2}, 4'b0000);

        // 3-cycle pulse on din[1] is rejected.
        for (int c = 1; c <= 10; c++) begin
            din = {2'b00, (c <= 3), 1'b0};
            step();
            check($sformatf("glitch3 c%0d dout", c), dout, 4'b0000);
            check($sformatf("glitch3 c%0d edges", c), rise | fall | {3'b000, any_edge}, 4'b0000);
        end

        // 4-cycle pulse on din[1] is accepted, then released.
        for (int c = 1; c <= 12; c++) begin
            din = {2'b00, (c <= 4), 1'b0};
            step();
            check($sformatf("pulse4 c%0d dout", c), dout, (c >= 6 && c <= 9) ? 4'b0010 : 4'b0000);
            check($sformatf("pulse4 c%0d rise", c), rise, (c == 6) ? 4'b0010 : 4'b0000);
            check($sformatf("pulse4 c%0d fall", c), fall, (c == 10) ? 4'b0010 : 4'b0000);
        end

        // en dropped after one counted sample on din[2]; count resumes from where it stopped.
        for (int c = 1; c <= 3; c++) begin
            din = 4'b0100;
            en  = 1'b1;
            step();
            check($sformatf("en pre c%0d dout", c), dout, 4'b0000);
        end
        for (int c = 1; c <= 5; c++) begin
            en = 1'b0;
            step();
            check($sformatf("en off c%0d dout", c), dout, 4'b0000);
            check($sformatf("en off c%0d edges", c), rise | fall | {3'b000, any_edge}, 4'b0000);
        end
        for (int c = 1; c <= 4; c++) begin
            en = 1'b1;
            step();
            check($sformatf("en on c%0d dout", c), dout, (c >= 3) ? 4'b0100 : 4'b0000);
            check($sformatf("en on c%0d rise", c), rise, (c == 3) ? 4'b0100 : 4'b0000);
        end

        // Reset while din[3] has counted two samples.
        for (int c = 1; c <= 4; c++) begin
            din = 4'b1100;
            step();
            check($sformatf("pre rst c%0d dout", c), dout, 4'b0100);
            check($sformatf("pre rst c%0d rise", c), rise, 4'b0000);
        end
        rst = 1'b1;
        step();
        check("mid rst dout", dout, 4'b0000);
        check("mid rst edges", rise | fall | {3'b000, any_edge}, 4'b0000);
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            check($sformatf("post rst c%0d dout", c), dout, (c >= 6) ? 4'b1100 : 4'b0000);
            check($sformatf("post rst c%0d rise", c), rise, (c == 6) ? 4'b1100 : 4'b0000);
            check($sformatf("post rst c%0d any", c), {3'b000, any_edge}, {3'b000, (c == 6)});
            check($sformatf("post rst c%0d fall", c), fall, 4'b0000);
        end

        // Short-latency instance: din differs from its reset level when reset drops.
        din2 = 4'b1010;
        step();
        check("dut2 held rst dout", dout2, 4'b0101);
        rst2 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("dut2 c%0d dout", c), dout2, (c >= 4) ? 4'b1010 : 4'b0101);
            check($sformatf("dut2 c%0d rise", c), rise2, (c == 4) ? 4'b1010 : 4'b0000);
            check($sformatf("dut2 c%0d fall", c), fall2, (c == 4) ? 4'b0101 : 4'b0000);
            check($sformatf("dut2 c%0d any", c), {3'b000, any_edge2}, {3'b000, (c == 4)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
